// File: rtl/mov_const_seq.sv
// Constant-build sequencer: splits a 64-bit value into one MOVZ plus up to
// three MOVK commands, lowest halfword first, one command per handshake.
module mov_const_seq #(
    parameter int RD_W      = 5,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [63:0]     req_value,
    input  logic [RD_W-1:0] req_rd,
    output logic            op_valid,
    input  logic            op_ready,
    output logic            op_movk,
    output logic [1:0]      op_shamt,
    output logic [15:0]     op_imm16,
    output logic [RD_W-1:0] op_rd,
    output logic            op_last,
    output logic            busy,
    output logic            done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Halfwords that need a command; a zero value still needs its MOVZ.
    function automatic logic [3:0] pend_mask(input logic [63:0] v);
        logic [3:0] m;
        if (SKIP_ZERO) begin
            m[0] = (v[15:0]  != 16'h0000);
            m[1] = (v[31:16] != 16'h0000);
            m[2] = (v[47:32] != 16'h0000);
            m[3] = (v[63:48] != 16'h0000);
        end else begin
            m = 4'b1111;
        end
        if (m == 4'b0000) begin
            m = 4'b0001;
        end else begin
            m = m;
        end
        return m;
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [3:0] p);
        logic [1:0] idx;
        casez (p)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic is_single(input logic [3:0] p);
        return (p != 4'b0000) && ((p & (p - 4'b0001)) == 4'b0000);
    endfunction

    logic [0:0]      state_r;
    logic [3:0]      pend_r;
    logic [63:0]     value_r;
    logic [RD_W-1:0] rd_r;
    logic            first_r;
    logic            done_r;

    logic [1:0]      cur_idx_s;
    logic [15:0]     cur_imm_s;
    logic            cur_last_s;
    logic            issuing_s;

    // Decode the current command from the pending mask and latched value.
    always_comb begin
        cur_idx_s  = lowest_idx(pend_r);
        cur_last_s = is_single(pend_r);
        issuing_s  = (state_r == ST_ISSUE);
        case (cur_idx_s)
            2'd0:    cur_imm_s = value_r[15:0];
            2'd1:    cur_imm_s = value_r[31:16];
            2'd2:    cur_imm_s = value_r[47:32];
            2'd3:    cur_imm_s = value_r[63:48];
            default: cur_imm_s = 16'h0000;
        endcase
    end

    // Outputs come only from registered state; gating by state keeps them zero in IDLE.
    assign req_ready = !issuing_s;
    assign busy      = issuing_s;
    assign done      = done_r;
    assign op_valid  = issuing_s;
    assign op_movk   = issuing_s && !first_r;
    assign op_shamt  = issuing_s ? cur_idx_s : 2'd0;
    assign op_imm16  = issuing_s ? cur_imm_s : 16'h0000;
    assign op_rd     = issuing_s ? rd_r : {RD_W{1'b0}};
    assign op_last   = issuing_s && cur_last_s;

    // Sequencer state: accept in IDLE, retire one halfword per handshake in ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            pend_r  <= 4'b0000;
            value_r <= 64'h0;
            rd_r    <= {RD_W{1'b0}};
            first_r <= 1'b0;
            done_r  <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            done_r <= 1'b0;
            if (req_valid) begin
                state_r <= ST_ISSUE;
                pend_r  <= pend_mask(req_value);
                value_r <= req_value;
                rd_r    <= req_rd;
                first_r <= 1'b1;
            end else begin
                state_r <= ST_IDLE;
            end
        end else begin
            done_r <= 1'b0;
            if (op_ready) begin
                pend_r  <= pend_r & (pend_r - 4'b0001);
                first_r <= 1'b0;
                if (cur_last_s) begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b1;
                end else begin
                    state_r <= ST_ISSUE;
                end
            end else begin
                state_r <= ST_ISSUE;
            end
        end
    end

endmodule

// File: tb/tb_mov_const_seq.sv
// Randomised bench for mov_const_seq: one instance skips zero halfwords, the
// other always issues four; both are checked against an op-list reference model.
module tb_mov_const_seq;

    localparam int RD_W = 5;

    typedef struct packed {
        logic        movk;
        logic [1:0]  sh;
        logic [15:0] imm;
        logic        last;
    } op_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            req_valid [2];
    logic            req_ready [2];
    logic [63:0]     req_value [2];
    logic [RD_W-1:0] req_rd    [2];
    logic            op_valid  [2];
    logic            op_ready  [2];
    logic            op_movk   [2];
    logic [1:0]      op_shamt  [2];
    logic [15:0]     op_imm16  [2];
    logic [RD_W-1:0] op_rd     [2];
    logic            op_last   [2];
    logic            busy      [2];
    logic            done      [2];

    int  n_tests = 0;
    int  n_fail  = 0;
    op_t exp_q[$];

    mov_const_seq #(.RD_W(RD_W), .SKIP_ZERO(1'b1)) u_skip (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_value(req_value[0]), .req_rd(req_rd[0]),
        .op_valid(op_valid[0]), .op_ready(op_ready[0]),
        .op_movk(op_movk[0]), .op_shamt(op_shamt[0]),
        .op_imm16(op_imm16[0]), .op_rd(op_rd[0]),
        .op_last(op_last[0]), .busy(busy[0]), .done(done[0])
    );

    mov_const_seq #(.RD_W(RD_W), .SKIP_ZERO(1'b0)) u_full (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_value(req_value[1]), .req_rd(req_rd[1]),
        .op_valid(op_valid[1]), .op_ready(op_ready[1]),
        .op_movk(op_movk[1]), .op_shamt(op_shamt[1]),
        .op_imm16(op_imm16[1]), .op_rd(op_rd[1]),
        .op_last(op_last[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: list of commands the value should produce, in issue order.
    task automatic build_exp(input int s, input logic [63:0] v);
        op_t  t;
        logic [15:0] hw;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            hw = 16'((v >> (16 * i)) & 64'hFFFF);
            if (s == 1 || hw != 16'h0000) begin
                t.movk = (exp_q.size() != 0);
                t.sh   = 2'(i);
                t.imm  = hw;
                t.last = 1'b0;
                exp_q.push_back(t);
            end
        end
        if (exp_q.size() == 0) begin
            t = '{movk: 1'b0, sh: 2'd0, imm: 16'h0000, last: 1'b0};
            exp_q.push_back(t);
        end
        t = exp_q.pop_back();
        t.last = 1'b1;
        exp_q.push_back(t);
    endtask

    task automatic check_idle_reset(input int s, input string tag);
        check_eq({tag, "_op_valid"},  op_valid[s],  64'd0);
        check_eq({tag, "_busy"},      busy[s],      64'd0);
        check_eq({tag, "_done"},      done[s],      64'd0);
        check_eq({tag, "_req_ready"}, req_ready[s], 64'd1);
        check_eq({tag, "_op_movk"},   op_movk[s],   64'd0);
        check_eq({tag, "_op_shamt"},  op_shamt[s],  64'd0);
        check_eq({tag, "_op_imm16"},  op_imm16[s],  64'd0);
        check_eq({tag, "_op_rd"},     op_rd[s],     64'd0);
        check_eq({tag, "_op_last"},   op_last[s],   64'd0);
    endtask

    // Present a request for one edge; with hold, keep req_valid up carrying hv/hrd.
    task automatic do_accept(input int s, input logic [63:0] v, input logic [RD_W-1:0] rd,
                             input bit hold, input logic [63:0] hv, input logic [RD_W-1:0] hrd);
        @(negedge clk);
        check_eq("accept_ready", req_ready[s], 64'd1);
        req_valid[s] = 1'b1;
        req_value[s] = v;
        req_rd[s]    = rd;
        @(posedge clk);
        #1;
        if (hold) begin
            req_value[s] = hv;
            req_rd[s]    = hrd;
        end else begin
            req_valid[s] = 1'b0;
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1,0,1,1 then ready, 2: random.
    task automatic issue_phase(input int s, input logic [63:0] v, input logic [RD_W-1:0] rd,
                               input int mode);
        int          n;
        int          idx;
        int          cyc;
        logic        r;
        op_t         e;
        logic [6:0]  pat;
        pat = 7'b1101001;
        build_exp(s, v);
        n   = exp_q.size();
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 64) begin
            @(negedge clk);
            e = exp_q[idx];
            check_eq("op_valid",  op_valid[s],  64'd1);
            check_eq("busy",      busy[s],      64'd1);
            check_eq("req_ready", req_ready[s], 64'd0);
            check_eq("done_low",  done[s],      64'd0);
            check_eq("op_movk",   op_movk[s],   {63'd0, e.movk});
            check_eq("op_shamt",  op_shamt[s],  {62'd0, e.sh});
            check_eq("op_imm16",  op_imm16[s],  {48'd0, e.imm});
            check_eq("op_last",   op_last[s],   {63'd0, e.last});
            check_eq("op_rd",     op_rd[s],     64'(rd));
            if (mode == 0) begin
                r = 1'b1;
            end else if (mode == 1) begin
                r = (cyc < 7) ? pat[cyc] : 1'b1;
            end else begin
                r = 1'($urandom_range(0, 1));
            end
            op_ready[s] = r;
            if (r) idx++;
            cyc++;
        end
        if (idx < n) check_eq("timeout_ops_issued", 64'(idx), 64'(n));
        if (mode == 0) check_eq("busy_cycles", 64'(cyc), 64'(n));
        @(negedge clk);
        op_ready[s] = 1'b0;
        check_eq("done_pulse",     done[s],      64'd1);
        check_eq("done_req_ready", req_ready[s], 64'd1);
        check_eq("done_op_valid",  op_valid[s],  64'd0);
        check_eq("done_busy",      busy[s],      64'd0);
    endtask

    task automatic run(input int s, input logic [63:0] v, input logic [RD_W-1:0] rd, input int mode);
        do_accept(s, v, rd, 1'b0, 64'd0, '0);
        issue_phase(s, v, rd, mode);
        @(negedge clk);
        check_eq("done_one_cycle", done[s], 64'd0);
    endtask

    initial begin
        logic [63:0] v;
        logic [63:0] hv;
        logic [3:0]  zm;
        int          s;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_value[i] = 64'd0;
            req_rd[i]    = '0;
            op_ready[i]  = 1'b0;
        end
        #3;
        check_idle_reset(0, "rst_skip");
        check_idle_reset(1, "rst_full");
        #9;
        reset = 1'b0;

        run(0, 64'h0000_0000_0000_1234, 5'd3, 0);
        run(0, 64'h1111_0000_3333_0000, 5'd7, 0);
        run(0, 64'h0000_0000_0000_0000, 5'd1, 0);
        run(0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 1);

        // Full-issue instance with a second request held throughout.
        hv = 64'hDEAD_0000_BEEF_0000;
        do_accept(1, 64'h0000_0000_0001_0000, 5'd9, 1'b1, hv, 5'd4);
        issue_phase(1, 64'h0000_0000_0001_0000, 5'd9, 0);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        issue_phase(1, hv, 5'd4, 0);
        @(negedge clk);
        check_eq("held_done_one_cycle", done[1], 64'd0);

        // Reset while the second of three ops is stalled.
        do_accept(0, 64'h0000_AAAA_BBBB_CCCC, 5'd6, 1'b0, 64'd0, '0);
        @(negedge clk);
        check_eq("mid_first_shamt", op_shamt[0], 64'd0);
        op_ready[0] = 1'b1;
        @(negedge clk);
        check_eq("mid_second_shamt", op_shamt[0], 64'd1);
        check_eq("mid_second_movk",  op_movk[0],  64'd1);
        op_ready[0] = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_idle_reset(0, "async_rst");
        @(negedge clk);
        reset = 1'b0;
        run(0, 64'h5555_0000_0000_0000, 5'd2, 0);

        for (int k = 0; k < 30; k++) begin
            s  = $urandom_range(0, 1);
            v  = {$urandom, $urandom};
            zm = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                if (zm[i]) v = v & ~(64'hFFFF << (16 * i));
            end
            run(s, v, 5'($urandom_range(0, 31)), 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
